// File: rtl/roce_pacing_pkg.sv
// Shared types and ACK signature constants for the RoCE ACK pacing arbiter.
package roce_pacing_pkg;

  localparam int unsigned DATA_W = 512;
  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned GAP_W  = 8;

  // ACK signature: EtherType-like tag in the low bytes plus a fixed opcode byte.
  localparam logic [15:0] ACK_ETH_SIG = 16'h0245;
  localparam int unsigned ACK_ETH_LSB = 0;
  localparam int unsigned ACK_ETH_W   = 16;
  localparam logic [7:0]  ACK_OPCODE  = 8'h11;
  localparam int unsigned ACK_OPC_LSB = 224;
  localparam int unsigned ACK_OPC_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  // True when a first beat carries the ACK signature.
  function automatic logic is_ack_beat(input logic [DATA_W-1:0] d);
    return (d[ACK_ETH_LSB +: ACK_ETH_W] == ACK_ETH_SIG) &&
           (d[ACK_OPC_LSB +: ACK_OPC_W] == ACK_OPCODE);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after the last grant wins.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_idx,
  output logic [IW-1:0] win_idx,
  output logic          win_valid
);

  logic [31:0] cand;

  // Walk ports starting one past the last grant, wrapping modulo N.
  always_comb begin
    win_idx   = last_idx;
    win_valid = 1'b0;
    cand      = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = (32'(last_idx) + 32'(i)) % 32'(N);
      if (!win_valid && req[cand[IW-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/roce_ack_pacing_arbiter.sv
// Merges N AXI4-Stream inputs packet-by-packet and enforces a quiet gap after ACKs.
module roce_ack_pacing_arbiter
  import roce_pacing_pkg::*;
#(
  parameter int unsigned N_PORTS  = 2,
  parameter int unsigned CNT_BITS = 32,
  localparam int unsigned IDX_W   = $clog2(N_PORTS)
) (
  input  logic                        nclk,
  input  logic                        nresetn,
  input  logic                        gap_en,
  input  logic [GAP_W-1:0]            gap_cycles,
  input  logic [N_PORTS*DATA_W-1:0]   s_axis_tdata,
  input  logic [N_PORTS*KEEP_W-1:0]   s_axis_tkeep,
  input  logic [N_PORTS-1:0]          s_axis_tlast,
  input  logic [N_PORTS-1:0]          s_axis_tvalid,
  output logic [N_PORTS-1:0]          s_axis_tready,
  output logic [DATA_W-1:0]           m_axis_tdata,
  output logic [KEEP_W-1:0]           m_axis_tkeep,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [IDX_W-1:0]            grant_idx,
  output logic [CNT_BITS-1:0]         ack_count,
  output logic [CNT_BITS-1:0]         stall_count
);

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic             ack_flag;
  logic             first_beat;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;
  logic             streaming;
  logic             beat_hs;
  logic             pkt_is_ack;
  logic [31:0]      data_base;
  logic [31:0]      keep_base;

  rr_arbiter #(
    .N  (N_PORTS),
    .IW (IDX_W)
  ) u_arb (
    .req       (s_axis_tvalid),
    .last_idx  (grant_idx),
    .win_idx   (arb_idx),
    .win_valid (arb_valid)
  );

  // Unregistered datapath: granted port is wired straight through while streaming.
  always_comb begin
    streaming     = nresetn && (state == ST_STREAM);
    data_base     = 32'(grant_idx) * 32'(DATA_W);
    keep_base     = 32'(grant_idx) * 32'(KEEP_W);
    m_axis_tdata  = s_axis_tdata[data_base +: DATA_W];
    m_axis_tkeep  = s_axis_tkeep[keep_base +: KEEP_W];
    m_axis_tlast  = s_axis_tlast[grant_idx];
    m_axis_tvalid = streaming && s_axis_tvalid[grant_idx];
    s_axis_tready = '0;
    if (streaming) begin
      s_axis_tready[grant_idx] = m_axis_tready;
    end
    beat_hs    = m_axis_tvalid && m_axis_tready;
    pkt_is_ack = first_beat ? is_ack_beat(m_axis_tdata) : ack_flag;
  end

  // Packet FSM, grant register, gap countdown and statistics.
  always_ff @(posedge nclk) begin
    if (!nresetn) begin
      state       <= ST_IDLE;
      grant_idx   <= IDX_W'(N_PORTS - 1);
      gap_cnt     <= '0;
      ack_flag    <= 1'b0;
      first_beat  <= 1'b1;
      ack_count   <= '0;
      stall_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_idx <= arb_idx;
            state     <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (beat_hs) begin
            first_beat <= 1'b0;
            if (first_beat) begin
              ack_flag <= is_ack_beat(m_axis_tdata);
            end
            if (m_axis_tlast) begin
              first_beat <= 1'b1;
              ack_flag   <= 1'b0;
              if (pkt_is_ack) begin
                ack_count <= ack_count + CNT_BITS'(1);
              end
              if (pkt_is_ack && gap_en && (gap_cycles != '0)) begin
                gap_cnt <= gap_cycles;
                state   <= ST_GAP;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt - GAP_W'(1);
          if (|s_axis_tvalid) begin
            stall_count <= stall_count + CNT_BITS'(1);
          end
          if (gap_cnt <= GAP_W'(1)) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_roce_ack_pacing_arbiter.sv
// Directed bench for roce_ack_pacing_arbiter with a packet-level reference model.
module tb_roce_ack_pacing_arbiter;

  localparam int NP = 2;
  localparam int DW = 512;
  localparam int KW = 64;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    int            cyc;
    int            port;
    int            pkt;
    int            beat;
  } olog_t;

  logic              nclk = 1'b0;
  logic              nresetn = 1'b0;
  logic              gap_en = 1'b0;
  logic [7:0]        gap_cycles = 8'h00;
  logic [NP*DW-1:0]  s_tdata = '0;
  logic [NP*KW-1:0]  s_tkeep = '0;
  logic [NP-1:0]     s_tlast = '0;
  logic [NP-1:0]     s_tvalid = '0;
  logic              m_tready = 1'b1;

  logic [NP-1:0]     s_tready, s4_tready;
  logic [DW-1:0]     m_tdata, m4_tdata;
  logic [KW-1:0]     m_tkeep, m4_tkeep;
  logic              m_tlast, m4_tlast, m_tvalid, m4_tvalid;
  logic              grant_idx, grant4;
  logic [31:0]       ack_count, stall_count;
  logic [3:0]        ack4, stall4;

  roce_ack_pacing_arbiter #(.N_PORTS(NP), .CNT_BITS(32)) dut (
    .nclk(nclk), .nresetn(nresetn), .gap_en(gap_en), .gap_cycles(gap_cycles),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .grant_idx(grant_idx), .ack_count(ack_count), .stall_count(stall_count));

  roce_ack_pacing_arbiter #(.N_PORTS(NP), .CNT_BITS(4)) dut4 (
    .nclk(nclk), .nresetn(nresetn), .gap_en(gap_en), .gap_cycles(gap_cycles),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s4_tready),
    .m_axis_tdata(m4_tdata), .m_axis_tkeep(m4_tkeep), .m_axis_tlast(m4_tlast),
    .m_axis_tvalid(m4_tvalid), .m_axis_tready(m_tready),
    .grant_idx(grant4), .ack_count(ack4), .stall_count(stall4));

  always #5 nclk = ~nclk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          rand_mode = 1'b0;
  logic [NP-1:0] hs_q = '0;
  beat_t       pq[NP][$];
  olog_t       olog[$];

  // Reference model: packet-level view of the arbiter.
  bit          mb_busy = 1'b0;
  int          mb_port = 0;
  bit          mb_first = 1'b1;
  bit          mb_ack = 1'b0;
  int          mb_quiet = 0;
  int          mb_last = NP - 1;
  int unsigned m_ackc = 0;
  int unsigned m_stallc = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic beat_t mk_beat(input int p, input int pk, input int b, input int nb, input int kind);
    beat_t x;
    x.data = '0;
    x.data[DW-1:DW-32] = $urandom;
    x.data[63:32]   = {8'(p), 8'(pk), 8'(b), 8'h5A};
    x.data[15:0]    = 16'hA5A5;
    x.data[231:224] = 8'h11;
    if (kind == 1 && b == 0) x.data[15:0] = 16'h0245;
    if (kind == 2 && b == 0) begin
      x.data[15:0]    = 16'h0245;
      x.data[231:224] = 8'h22;
    end
    if (kind == 3 && b == 1) x.data[15:0] = 16'h0245;
    x.keep = {8'(pk), 8'(b), 48'hFFFF_FFFF_FFFF};
    x.last = (b == nb - 1);
    return x;
  endfunction

  // kind: 0 plain, 1 ACK, 2 ACK tag with wrong opcode, 3 ACK tag only on beat 1.
  task automatic load(input int p, input int pk, input int nb, input int kind);
    for (int b = 0; b < nb; b++) pq[p].push_back(mk_beat(p, pk, b, nb, kind));
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < NP; p++) begin
      if (pq[p].size() > 0) begin
        s_tvalid[p]           = 1'b1;
        s_tdata[p*DW +: DW]   = pq[p][0].data;
        s_tkeep[p*KW +: KW]   = pq[p][0].keep;
        s_tlast[p]            = pq[p][0].last;
      end else begin
        s_tvalid[p]           = 1'b0;
        s_tdata[p*DW +: DW]   = '0;
        s_tkeep[p*KW +: KW]   = '0;
        s_tlast[p]            = 1'b0;
      end
    end
    m_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic tick();
    @(posedge nclk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (hs_q[p] && pq[p].size() > 0) void'(pq[p].pop_front());
    end
    drive_inputs();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic flush();
    for (int p = 0; p < NP; p++) pq[p].delete();
    drive_inputs();
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while ((pq[0].size() > 0 || pq[1].size() > 0 || mb_busy || mb_quiet > 0) && n < budget) begin
      tick();
      n++;
    end
    chki({nm, "_drained"}, int'(n < budget), 1);
    ticks(2);
  endtask

  task automatic wait_log(input string nm, input int cnt, input int budget);
    int n;
    n = 0;
    while (olog.size() < cnt && n < budget) begin
      tick();
      n++;
    end
    chki({nm, "_seen"}, int'(n < budget), 1);
  endtask

  task automatic model_step();
    logic [DW-1:0] d;
    if (!nresetn) begin
      mb_busy = 1'b0; mb_quiet = 0; mb_last = NP - 1; mb_first = 1'b1; mb_ack = 1'b0;
      m_ackc = 0; m_stallc = 0;
    end else if (mb_busy) begin
      if (s_tvalid[mb_port] && m_tready) begin
        d = s_tdata[mb_port*DW +: DW];
        if (mb_first) mb_ack = (d[15:0] == 16'h0245) && (d[231:224] == 8'h11);
        mb_first = 1'b0;
        if (s_tlast[mb_port]) begin
          mb_busy  = 1'b0;
          mb_first = 1'b1;
          if (mb_ack) begin
            m_ackc++;
            if (gap_en && gap_cycles != 8'h00) mb_quiet = int'(gap_cycles);
          end
        end
      end
    end else if (mb_quiet > 0) begin
      if (|s_tvalid) m_stallc++;
      mb_quiet--;
    end else if (|s_tvalid) begin
      for (int k = 1; k <= NP; k++) begin
        if (!mb_busy && s_tvalid[(mb_last + k) % NP]) begin
          mb_port = (mb_last + k) % NP;
          mb_busy = 1'b1;
        end
      end
      mb_last  = mb_port;
      mb_first = 1'b1;
    end
  endtask

  // Per-cycle compare against the model, then advance it to the next edge.
  initial begin
    logic          exp_v;
    logic [NP-1:0] exp_rdy;
    forever begin
      @(negedge nclk);
      cyc++;
      hs_q = s_tvalid & s_tready;
      if (m_tvalid && m_tready)
        olog.push_back('{cyc, int'(m_tdata[63:56]), int'(m_tdata[55:48]), int'(m_tdata[47:40])});
      exp_v   = nresetn && mb_busy && s_tvalid[mb_port];
      exp_rdy = '0;
      if (nresetn && mb_busy) exp_rdy[mb_port] = m_tready;
      chki("m_tvalid", int'(m_tvalid), int'(exp_v));
      chki("m_tvalid_c4", int'(m4_tvalid), int'(exp_v));
      chki("s_tready", int'(s_tready), int'(exp_rdy));
      chki("s_tready_c4", int'(s4_tready), int'(exp_rdy));
      chki("grant_idx", int'(grant_idx), mb_last);
      chki("grant_idx_c4", int'(grant4), mb_last);
      chki("ack_count", int'(ack_count), int'(m_ackc));
      chki("stall_count", int'(stall_count), int'(m_stallc));
      chki("ack_count_c4", int'(ack4), int'(m_ackc % 16));
      chki("stall_count_c4", int'(stall4), int'(m_stallc % 16));
      if (exp_v) begin
        chk("m_tdata", m_tdata, s_tdata[mb_port*DW +: DW]);
        chk("m_tkeep", DW'(m_tkeep), DW'(s_tkeep[mb_port*KW +: KW]));
        chki("m_tlast", int'(m_tlast), int'(s_tlast[mb_port]));
        chk("m_tdata_c4", m4_tdata, s_tdata[mb_port*DW +: DW]);
        chk("m_tkeep_c4", DW'(m4_tkeep), DW'(s_tkeep[mb_port*KW +: KW]));
        chki("m_tlast_c4", int'(m4_tlast), int'(s_tlast[mb_port]));
      end
      model_step();
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_inputs();
    ticks(3);
    nresetn = 1'b1;
    tick();
    chki("rst_grant_idx", int'(grant_idx), 1);
    chki("rst_ack_count", int'(ack_count), 0);
    chki("rst_stall_count", int'(stall_count), 0);
    chki("rst_m_tvalid", int'(m_tvalid), 0);

    // Two ports, back-to-back non-ACK 4-beat packets.
    gap_en = 1'b1; gap_cycles = 8'd3;
    olog.delete();
    load(0, 1, 4, 0); load(1, 1, 4, 0); load(0, 2, 4, 0); load(1, 2, 4, 0);
    drive_inputs();
    drain("rr", 200);
    chki("rr_beats", olog.size(), 16);
    if (olog.size() == 16) begin
      for (int k = 0; k < 4; k++) begin
        chki("rr_port_order", olog[4*k].port, k % 2);
        chki("rr_last_beat", olog[4*k+3].beat, 3);
      end
      for (int k = 1; k < 4; k++) chki("rr_idle_gap", olog[4*k].cyc - olog[4*k-1].cyc, 2);
    end

    // Single-beat ACK with long gap, port 1 pending throughout.
    gap_en = 1'b1; gap_cycles = 8'h55;
    olog.delete();
    load(0, 3, 1, 1); load(1, 3, 4, 0);
    drive_inputs();
    wait_log("ack_gap", 1, 20);
    ticks(10);
    gap_cycles = 8'h03; gap_en = 1'b0;
    drain("ack_gap", 300);
    chki("gap_beats", olog.size(), 5);
    if (olog.size() == 5) begin
      chki("gap_first_port", olog[0].port, 0);
      chki("gap_second_port", olog[1].port, 1);
      chki("gap_spacing", olog[1].cyc - olog[0].cyc, 87);
    end
    chki("gap_stall_count", int'(stall_count), 85);
    chki("gap_ack_count", int'(ack_count), 1);
    chki("gap_stall_count_c4", int'(stall4), 5);

    // Gap disabled: back-to-back ACKs and near-miss signatures.
    gap_en = 1'b0; gap_cycles = 8'h10;
    olog.delete();
    load(0, 4, 1, 1); load(0, 5, 1, 1); load(0, 6, 1, 1);
    load(0, 7, 2, 1); load(0, 8, 2, 3); load(0, 9, 1, 2);
    drive_inputs();
    drain("nogap", 200);
    chki("nogap_beats", olog.size(), 8);
    if (olog.size() == 8) begin
      chki("nogap_spacing1", olog[1].cyc - olog[0].cyc, 2);
      chki("nogap_spacing2", olog[2].cyc - olog[1].cyc, 2);
    end
    chki("nogap_ack_count", int'(ack_count), 5);
    gap_en = 1'b1; gap_cycles = 8'h00;
    olog.delete();
    load(0, 10, 1, 1); load(0, 11, 1, 1);
    drive_inputs();
    drain("zerogap", 100);
    chki("zerogap_beats", olog.size(), 2);
    if (olog.size() == 2) chki("zerogap_spacing", olog[1].cyc - olog[0].cyc, 2);
    chki("zerogap_ack_count", int'(ack_count), 7);

    // Random backpressure on a 6-beat packet from port 1 while port 0 waits.
    gap_en = 1'b0;
    olog.delete();
    rand_mode = 1'b1;
    load(1, 12, 6, 0);
    drive_inputs();
    wait_log("bp", 1, 50);
    load(0, 13, 2, 0);
    drive_inputs();
    drain("bp", 400);
    rand_mode = 1'b0;
    drive_inputs();
    chki("bp_beats", olog.size(), 8);
    if (olog.size() == 8) begin
      for (int b = 0; b < 6; b++) begin
        chki("bp_port", olog[b].port, 1);
        chki("bp_beat_order", olog[b].beat, b);
      end
      chki("bp_next_port", olog[6].port, 0);
    end

    // Reset in the middle of a gap.
    gap_en = 1'b1; gap_cycles = 8'd30;
    olog.delete();
    load(0, 14, 1, 1);
    drive_inputs();
    wait_log("rst_gap", 1, 20);
    ticks(5);
    load(1, 15, 4, 0);
    drive_inputs();
    ticks(3);
    nresetn = 1'b0;
    flush();
    tick();
    chki("rstgap_m_tvalid", int'(m_tvalid), 0);
    chki("rstgap_ack_count", int'(ack_count), 0);
    chki("rstgap_stall_count", int'(stall_count), 0);
    chki("rstgap_grant_idx", int'(grant_idx), 1);
    nresetn = 1'b1;
    tick();

    // Reset in the middle of a packet; the partial packet must not resume.
    olog.delete();
    load(1, 16, 6, 0);
    drive_inputs();
    wait_log("rst_pkt", 2, 30);
    nresetn = 1'b0;
    flush();
    tick();
    chki("rstpkt_m_tvalid", int'(m_tvalid), 0);
    chki("rstpkt_s_tready", int'(s_tready), 0);
    nresetn = 1'b1;
    tick();
    olog.delete();
    load(1, 17, 2, 0); load(0, 18, 2, 0);
    drive_inputs();
    drain("post_rst", 100);
    chki("post_rst_beats", olog.size(), 4);
    if (olog.size() == 4) begin
      chki("post_rst_first_port", olog[0].port, 0);
      chki("post_rst_second_pkt", olog[2].pkt, 17);
    end

    // Counter wrap on the narrow-counter instance.
    gap_en = 1'b0;
    olog.delete();
    for (int i = 0; i < 17; i++) load(0, 20 + i, 1, 1);
    drive_inputs();
    drain("wrap", 400);
    chki("wrap_beats", olog.size(), 17);
    chki("wrap_ack_count_c4", int'(ack4), 1);
    chki("wrap_ack_count", int'(ack_count), 17);

    ticks(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
